// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and the default operand width.
package mul_div_unit_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_RUN    = 2'b01;
    localparam logic [1:0] S_FINISH = 2'b10;

endpackage

// File: rtl/muldiv_datapath.sv
// Combinational single-iteration step (shift-add multiply / restoring divide)
// and the final sign fix-up that forms the HI/LO result.
module muldiv_datapath
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic [1:0]       op_i,
    input  logic             sign_a_i,
    input  logic             sign_b_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] shr_i,
    input  logic [WIDTH-1:0] opb_i,
    output logic [WIDTH-1:0] step_acc_o,
    output logic [WIDTH-1:0] step_shr_o,
    output logic [WIDTH-1:0] res_hi_o,
    output logic [WIDTH-1:0] res_lo_o,
    output logic             div_zero_o
);

    logic             is_div;
    logic             is_signed;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             ge;
    logic [2*WIDTH-1:0] prod;

    function automatic logic [2*WIDTH-1:0] neg_if2(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    assign is_div     = op_i[1];
    assign is_signed  = ~op_i[0];
    assign div_zero_o = is_div && (opb_i == '0);

    // Multiply: add multiplicand on LSB, then shift {carry, acc, multiplier} right.
    assign sum = {1'b0, acc_i} + (shr_i[0] ? {1'b0, opb_i} : '0);

    // Divide: shift {rem, quot} left and keep the trial subtraction if it fits.
    assign rem_sh = {acc_i, shr_i[WIDTH-1]};
    assign ge     = rem_sh >= {1'b0, opb_i};
    assign diff   = rem_sh[WIDTH-1:0] - opb_i;

    always_comb begin
        if (is_div) begin
            step_acc_o = ge ? diff : rem_sh[WIDTH-1:0];
            step_shr_o = {shr_i[WIDTH-2:0], ge};
        end else begin
            step_acc_o = sum[WIDTH:1];
            step_shr_o = {sum[0], shr_i[WIDTH-1:1]};
        end
    end

    assign prod = neg_if2({acc_i, shr_i}, is_signed && (sign_a_i ^ sign_b_i));

    always_comb begin
        if (is_div) begin
            res_hi_o = neg_if(acc_i, is_signed && sign_a_i);
            res_lo_o = div_zero_o ? '1 : neg_if(shr_i, is_signed && (sign_a_i ^ sign_b_i));
        end else begin
            res_hi_o = prod[2*WIDTH-1:WIDTH];
            res_lo_o = prod[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// EX-stage multiply/divide engine: 33-cycle MULT/MULTU/DIV/DIVU sequencer
// owning the architectural HI/LO pair, with MTHI/MTLO writes in IDLE.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic             HiWrite,
    input  logic             LoWrite,
    input  logic [WIDTH-1:0] WriteData,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d, dbz_q, dbz_d;
    logic [1:0]       op_q, op_d;
    logic             sa_q, sa_d, sb_q, sb_d;
    logic [WIDTH-1:0] acc_q, acc_d, shr_q, shr_d, opb_q, opb_d;

    logic             in_signed;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] step_acc, step_shr, res_hi, res_lo;
    logic             div_zero;

    assign in_signed = ~Op[0];
    assign a_mag     = (in_signed && OperandA[WIDTH-1]) ? -OperandA : OperandA;
    assign b_mag     = (in_signed && OperandB[WIDTH-1]) ? -OperandB : OperandB;

    muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
        .op_i       (op_q),
        .sign_a_i   (sa_q),
        .sign_b_i   (sb_q),
        .acc_i      (acc_q),
        .shr_i      (shr_q),
        .opb_i      (opb_q),
        .step_acc_o (step_acc),
        .step_shr_o (step_shr),
        .res_hi_o   (res_hi),
        .res_lo_o   (res_lo),
        .div_zero_o (div_zero)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        acc_d   = acc_q;
        shr_d   = shr_q;
        opb_d   = opb_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    // Divide shifts the dividend through shr; multiply shifts the multiplier.
                    op_d    = Op;
                    sa_d    = in_signed & OperandA[WIDTH-1];
                    sb_d    = in_signed & OperandB[WIDTH-1];
                    shr_d   = Op[1] ? a_mag : b_mag;
                    opb_d   = Op[1] ? b_mag : a_mag;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    if (HiWrite) hi_d = WriteData;
                    if (LoWrite) lo_d = WriteData;
                end
            end
            S_RUN: begin
                acc_d = step_acc;
                shr_d = step_shr;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FINISH;
            end
            S_FINISH: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                done_d  = 1'b1;
                dbz_d   = dbz_q | div_zero;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    always_ff @(posedge Clk) begin
        op_q  <= op_d;
        sa_q  <= sa_d;
        sb_q  <= sb_d;
        acc_q <= acc_d;
        shr_q <= shr_d;
        opb_q <= opb_d;
    end

    assign Hi        = hi_q;
    assign Lo        = lo_q;
    assign Busy      = (state_q != S_IDLE);
    assign Done      = done_q;
    assign DivByZero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected HI/LO queued at Start, popped on Done.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic        Clk, Reset, Start, HiWrite, LoWrite;
    logic [1:0]  Op;
    logic [31:0] OperandA, OperandB, WriteData;
    logic [31:0] Hi, Lo;
    logic        Busy, Done, DivByZero;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_q[$];
    logic [31:0] exp_hi, exp_lo;
    logic        exp_dbz;

    mul_div_unit dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op),
        .OperandA(OperandA), .OperandB(OperandB),
        .HiWrite(HiWrite), .LoWrite(LoWrite), .WriteData(WriteData),
        .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done), .DivByZero(DivByZero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic, {HI, LO}.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            OP_MULT:  begin q = sa * sb; p = q; end
            OP_MULTU: p = 64'(a) * 64'(b);
            default: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else if (op == OP_DIV) begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end else p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    always @(negedge Clk) begin
        if (Done) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: Done=1 with empty scoreboard");
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("result_hi", 64'(Hi), 64'(e[63:32]));
                chk("result_lo", 64'(Lo), 64'(e[31:0]));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after E33 with Done high.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int poke, input int lw, input bit wr_start);
        logic [63:0] r;
        int cyc;
        r = model(op, a, b);
        exp_q.push_back(r);
        Op = op; OperandA = a; OperandB = b; Start = 1'b1;
        if (wr_start) begin LoWrite = 1'b1; WriteData = 32'hDEAD_BEEF; end
        @(posedge Clk); #1;
        Start = 1'b0; LoWrite = 1'b0;
        cyc = 0;
        while (Busy && cyc < 40) begin
            cyc++;
            if (wr_start && cyc == 1) chk("start_wr_dropped", 64'(Lo), 64'(exp_lo));
            if (lw > 0 && cyc == lw + 1) chk("lo_write_busy", 64'(Lo), 64'(exp_lo));
            if (cyc == poke) begin
                Start = 1'b1; Op = OP_MULTU; OperandA = $urandom; OperandB = $urandom;
            end else Start = 1'b0;
            if (cyc == lw) begin LoWrite = 1'b1; WriteData = 32'hCAFE_F00D; end
            else LoWrite = 1'b0;
            @(posedge Clk); #1;
        end
        Start = 1'b0; LoWrite = 1'b0;
        chk("busy_len", 64'(cyc), 64'd33);
        chk("done_at_e33", 64'(Done), 64'd1);
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        if (op[1] && b == 32'd0) exp_dbz = 1'b1;
        chk("divbyzero", 64'(DivByZero), 64'(exp_dbz));
    endtask

    function automatic logic [31:0] pick(input bit allow_zero);
        case ($urandom_range(0, 7))
            0: return allow_zero ? 32'd0 : 32'd1;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        Reset = 1'b1; Start = 1'b0; Op = 2'b00; OperandA = '0; OperandB = '0;
        HiWrite = 1'b0; LoWrite = 1'b0; WriteData = '0;
        exp_hi = '0; exp_lo = '0; exp_dbz = 1'b0;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        chk("rst_hi", 64'(Hi), 64'd0);
        chk("rst_lo", 64'(Lo), 64'd0);
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_done", 64'(Done), 64'd0);
        chk("rst_dbz", 64'(DivByZero), 64'd0);

        HiWrite = 1'b1; WriteData = 32'h1234_5678;
        @(posedge Clk); #1 HiWrite = 1'b0;
        exp_hi = 32'h1234_5678;
        chk("mthi", 64'(Hi), 64'(exp_hi));
        chk("mthi_lo_kept", 64'(Lo), 64'(exp_lo));
        HiWrite = 1'b1; LoWrite = 1'b1; WriteData = 32'hA5A5_0F0F;
        @(posedge Clk); #1 HiWrite = 1'b0; LoWrite = 1'b0;
        exp_hi = 32'hA5A5_0F0F; exp_lo = 32'hA5A5_0F0F;
        chk("both_hi", 64'(Hi), 64'(exp_hi));
        chk("both_lo", 64'(Lo), 64'(exp_lo));

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0);
        @(posedge Clk); #1;
        chk("done_pulse_width", 64'(Done), 64'd0);
        chk("hi_hold", 64'(Hi), 64'(exp_hi));

        run_op(OP_MULT, -32'sd7, 32'd3, 0, 0, 1'b0);
        run_op(OP_DIV, -32'sd7, 32'd2, 0, 0, 1'b0);
        run_op(OP_DIVU, 32'd100, 32'd0, 0, 0, 1'b0);
        run_op(OP_DIVU, 32'd50, 32'd7, 0, 0, 1'b0);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 0, 1'b0);
        run_op(OP_MULT, 32'h0001_0003, 32'hFFFF_FF00, 0, 5, 1'b0);
        run_op(OP_DIVU, 32'hFFFF_FFF0, 32'd3, 0, 0, 1'b1);

        // Abort a MULTU with Reset sampled at E15.
        exp_q.push_back(model(OP_MULTU, 32'h0BAD_CAFE, 32'h1234_5678));
        Op = OP_MULTU; OperandA = 32'h0BAD_CAFE; OperandB = 32'h1234_5678; Start = 1'b1;
        @(posedge Clk); #1 Start = 1'b0;
        repeat (14) @(posedge Clk);
        #1 Reset = 1'b1;
        @(posedge Clk); #1 Reset = 1'b0;
        void'(exp_q.pop_back());
        exp_hi = '0; exp_lo = '0; exp_dbz = 1'b0;
        chk("abort_hi", 64'(Hi), 64'd0);
        chk("abort_lo", 64'(Lo), 64'd0);
        chk("abort_busy", 64'(Busy), 64'd0);
        chk("abort_done", 64'(Done), 64'd0);
        chk("abort_dbz", 64'(DivByZero), 64'd0);
        run_op(OP_MULTU, 32'h0BAD_CAFE, 32'h1234_5678, 0, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 3));
            run_op(op, pick(1'b1), pick(1'b1), 0, 0, 1'b0);
        end

        repeat (2) @(posedge Clk);
        #1 chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
